button_conditioner: RTL and testbench

Input conditioning stage for the clock/calendar board. It sits between the raw active-low pushbuttons and the time/date counter, feeding it the clean increase/decrease/change events. For each button it synchronises, debounces and edge-detects the input, and optionally adds hold-to-auto-repeat. This replaces the ad-hoc free-running tick-while-held dividers with one-cycle step pulses.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 tb/tb_button_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and press/release edge detector for active-low pushbuttons.
// Define BTN_AUTOREPEAT_EN to add hold-to-auto-repeat; otherwise repeat_pulse is tied low.
module button_conditioner #(
    parameter int N_BTN        = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 12_500_000,
    parameter int CNT_W        = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n_raw,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] step_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       db_cnt;
        logic                   level_q;
        logic                   press_q;
        logic                   release_q;
        logic                   rep_q;
        logic                   s;
        logic                   accept;
        logic                   level_nxt;

        // Raw input is active-low; flops idle at 1 so reset reads as released.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_raw[i]};
            end
        end

        assign s         = ~sync_q[SYNC_STAGES-1];
        assign accept    = (s != level_q) && (db_cnt == DEB_LAST);
        assign level_nxt = accept ? ~level_q : level_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (s == level_q) begin
                    db_cnt <= '0;
                end else if (accept) begin
                    db_cnt    <= '0;
                    level_q   <= ~level_q;
                    press_q   <= ~level_q;
                    release_q <= level_q;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} rep_state_t;

        localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
        localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

        rep_state_t       state;
        logic [CNT_W-1:0] rep_cnt;

        // Keyed off the next debounced level so no repeat can land in the first released cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                rep_cnt <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (!level_nxt) begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (accept) begin
                                state   <= HOLD_WAIT;
                                rep_cnt <= '0;
                            end
                        end
                        HOLD_WAIT: begin
                            if (rep_cnt == HOLD_LAST) begin
                                rep_q   <= 1'b1;
                                rep_cnt <= '0;
                                state   <= REPEAT;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rep_cnt == REP_LAST) begin
                                rep_q   <= 1'b1;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            rep_cnt <= '0;
                        end
                    endcase
                end
            end
        end
`else
        assign rep_q = 1'b0;
`endif

        assign pressed[i]       = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = rep_q;
        assign step_pulse[i]    = press_q | rep_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a sample-window reference model and per-cycle compare.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int HC = 10;
    localparam int RC = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_n_raw = '1;
    logic [NB-1:0] pressed, press_pulse, release_pulse, repeat_pulse, step_pulse;

    button_conditioner #(
        .N_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB),
        .HOLD_CYC(HC), .REPEAT_CYC(RC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_n_raw(btn_n_raw),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: a level is accepted once the last DB synchronised samples all disagree with it;
    // repeats fall at HC, HC+RC, ... cycles after the press while the level stays high.
    bit            m_raw [NB][SS+DB];
    logic [NB-1:0] m_pressed, m_press, m_rel, m_rep;
    int            m_age [NB];
    bit            differ, np;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                for (int j = 0; j < SS + DB; j++) m_raw[i][j] = 1'b1;
                m_age[i] = 0;
            end
            m_pressed = '0; m_press = '0; m_rel = '0; m_rep = '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                differ = 1'b1;
                for (int j = SS - 1; j <= SS + DB - 2; j++)
                    if (!m_raw[i][j] == m_pressed[i]) differ = 1'b0;
                np = differ ? !m_pressed[i] : m_pressed[i];
                m_press[i] = np & !m_pressed[i];
                m_rel[i]   = !np & m_pressed[i];
                if (m_press[i]) m_age[i] = 0;
                else if (np) m_age[i] = m_age[i] + 1;
                m_rep[i] = AR && np && !m_press[i] && m_age[i] >= HC && ((m_age[i] - HC) % RC == 0);
                m_pressed[i] = np;
                for (int j = SS + DB - 1; j > 0; j--) m_raw[i][j] = m_raw[i][j-1];
                m_raw[i][0] = btn_n_raw[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    int press_cnt [NB];
    int press_cyc [NB];
    int rel_cnt   [NB];
    int rel_cyc   [NB];
    int step_cnt  [NB];
    int rep_log[$];

    task automatic clear_log();
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] = 0; press_cyc[i] = -1;
            rel_cnt[i] = 0; rel_cyc[i] = -1; step_cnt[i] = 0;
        end
        rep_log.delete();
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        chk("pressed", pressed, m_pressed);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        chk("repeat_pulse", repeat_pulse, m_rep);
        chk("step_pulse", step_pulse, m_press | m_rep);
        for (int i = 0; i < NB; i++) begin
            if (press_pulse[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (release_pulse[i]) begin rel_cnt[i]++; rel_cyc[i] = cyc; end
            if (step_pulse[i])    step_cnt[i]++;
        end
        if (repeat_pulse[0]) rep_log.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t0, p0, tr, exp_reps, act_off;

    initial begin
        clear_log();
        tick(3);
        chk("reset_outputs", pressed | press_pulse | release_pulse | repeat_pulse | step_pulse, '0);
        rst_n = 1'b1;
        tick(2);

        // Clean press on channel 0, then hold through the auto-repeat window.
        clear_log();
        btn_n_raw[0] = 1'b0;
        t0 = cyc;
        tick(8);
        lit("s1_press_latency", press_cyc[0] - t0, 6);
        lit("s1_press_count", press_cnt[0], 1);
        lit("s1_step_count", step_cnt[0], 1);
        lit("s1_other_channels", press_cnt[1] + press_cnt[2], 0);
        p0 = press_cyc[0];
        tick(p0 + 27 - cyc);
        btn_n_raw[0] = 1'b1;
        tick(20);
        exp_reps = AR ? 5 : 0;
        lit("s4_repeat_count", rep_log.size(), exp_reps);
        for (int k = 0; k < exp_reps; k++) begin
            act_off = (k < rep_log.size()) ? rep_log[k] - p0 : -1;
            lit("s4_repeat_offset", act_off, 10 + 5 * k);
        end
        lit("s4_step_count", step_cnt[0], 1 + exp_reps);
        lit("s4_release_offset", rel_cyc[0] - p0, 33);
        lit("s4_release_count", rel_cnt[0], 1);

        // Three-cycle glitch on channel 1 is discarded.
        clear_log();
        btn_n_raw[1] = 1'b0;
        tick(3);
        btn_n_raw[1] = 1'b1;
        tick(10);
        lit("s2_glitch_press", press_cnt[1], 0);
        lit("s2_glitch_release", rel_cnt[1], 0);

        // Bounce on channel 2 for both press and release.
        clear_log();
        btn_n_raw[2] = 1'b0; tick(1);
        btn_n_raw[2] = 1'b1; tick(1);
        btn_n_raw[2] = 1'b0; tick(1);
        btn_n_raw[2] = 1'b1; tick(1);
        btn_n_raw[2] = 1'b0;
        t0 = cyc;
        tick(10);
        lit("s3_press_latency", press_cyc[2] - t0, 6);
        lit("s3_press_count", press_cnt[2], 1);
        btn_n_raw[2] = 1'b1; tick(1);
        btn_n_raw[2] = 1'b0; tick(1);
        btn_n_raw[2] = 1'b1; tick(1);
        btn_n_raw[2] = 1'b0; tick(1);
        btn_n_raw[2] = 1'b1;
        t0 = cyc;
        tick(10);
        lit("s3_release_latency", rel_cyc[2] - t0, 6);
        lit("s3_release_count", rel_cnt[2], 1);
        lit("s3_press_total", press_cnt[2], 1);

        // Two channels pressed together act independently and in step.
        clear_log();
        btn_n_raw[2:1] = 2'b00;
        t0 = cyc;
        tick(8);
        lit("simul_latency", press_cyc[1] - t0, 6);
        lit("simul_same_cycle", press_cyc[2] - press_cyc[1], 0);
        btn_n_raw[2:1] = 2'b11;
        tick(10);

        // Reset asserted while channel 0 is auto-repeating, button kept held.
        clear_log();
        btn_n_raw[0] = 1'b0;
        tick(18);
        rst_n = 1'b0;
        #1;
        chk("s6_reset_outputs", pressed | press_pulse | release_pulse | repeat_pulse | step_pulse, '0);
        tick(3);
        rst_n = 1'b1;
        tr = cyc;
        clear_log();
        tick(20);
        lit("s6_press_latency", press_cyc[0] - tr, 6);
        act_off = (rep_log.size() > 0) ? rep_log[0] - press_cyc[0] : -1;
        lit("s6_first_repeat", act_off, AR ? 10 : -1);
        btn_n_raw[0] = 1'b1;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
